// File: rtl/branch_pattern_table.sv
// Pattern history table of saturating counters with optional gshare
// indexing, a reset-time initialisation sweep and mispredict counters.
// Handshake: a lookup is taken on any cycle where fetch_valid=1 and ready=1;
// its result appears one cycle later with pred_valid=1. An update is taken on
// any cycle where mem_update=1 and ready=1. Both are dropped while ready=0,
// and there is no backpressure.
module branch_pattern_table #(
  parameter int CTR_WIDTH   = 2,
  parameter int INDEX_WIDTH = 6,
  parameter int GHR_WIDTH   = 6,
  parameter int USE_GSHARE  = 1,
  parameter int PC_LSB      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_valid,
  input  logic [31:0]            fetch_pc,
  output logic                   pred_valid,
  output logic                   pred_taken,
  output logic [CTR_WIDTH-1:0]   pred_counter,
  output logic [INDEX_WIDTH-1:0] pred_index,
  output logic                   ready,
  input  logic                   mem_update,
  input  logic [INDEX_WIDTH-1:0] mem_index,
  input  logic [CTR_WIDTH-1:0]   mem_counter,
  input  logic                   mem_actual_taken,
  output logic [GHR_WIDTH-1:0]   ghr,
  output logic [31:0]            perf_branches,
  output logic [31:0]            perf_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;

  localparam logic [CTR_WIDTH-1:0]   WEAK_NT = {1'b0, {(CTR_WIDTH-1){1'b1}}};
  localparam logic [CTR_WIDTH-1:0]   CTR_MAX = {CTR_WIDTH{1'b1}};
  localparam logic [CTR_WIDTH-1:0]   CTR_MIN = {CTR_WIDTH{1'b0}};
  localparam logic [CTR_WIDTH-1:0]   CTR_ONE = {{(CTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [INDEX_WIDTH-1:0] IDX_MAX = {INDEX_WIDTH{1'b1}};
  localparam logic [31:0]            PERF_MAX = 32'hFFFF_FFFF;

  // FSM states: sweeping the table after reset, then normal operation.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [INDEX_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic [CTR_WIDTH-1:0]   table_q [ENTRIES];
  logic [CTR_WIDTH-1:0]   table_d [ENTRIES];
  logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;
  logic [31:0]            perf_br_q, perf_br_d;
  logic [31:0]            perf_mp_q, perf_mp_d;
  logic                   pred_valid_q, pred_valid_d;
  logic [CTR_WIDTH-1:0]   pred_counter_q, pred_counter_d;
  logic [INDEX_WIDTH-1:0] pred_index_q, pred_index_d;

  logic                   run;
  logic                   upd_accept;
  logic                   mispredict;
  logic [CTR_WIDTH-1:0]   upd_new;
  logic [INDEX_WIDTH-1:0] fetch_idx;

  assign run        = (state_q == ST_RUN);
  assign upd_accept = run & mem_update;
  assign mispredict = (mem_counter[CTR_WIDTH-1] != mem_actual_taken);

  // Fetch index: PC slice, low bits optionally folded with committed history.
  always_comb begin
    fetch_idx = fetch_pc[PC_LSB +: INDEX_WIDTH];
    if (USE_GSHARE != 0) begin
      fetch_idx[GHR_WIDTH-1:0] = fetch_idx[GHR_WIDTH-1:0] ^ ghr_q;
    end
  end

  // Saturating step of the counter carried from fetch (not the live entry).
  always_comb begin
    upd_new = mem_counter;
    if (mem_actual_taken) begin
      if (mem_counter != CTR_MAX) upd_new = mem_counter + CTR_ONE;
    end else begin
      if (mem_counter != CTR_MIN) upd_new = mem_counter - CTR_ONE;
    end
  end

  // Sweep FSM and table write port: init writes first, updates only in RUN.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    table_d    = table_q;
    if (state_q == ST_INIT) begin
      table_d[init_ptr_q] = WEAK_NT;
      init_ptr_d          = init_ptr_q + IDX_ONE;
      if (init_ptr_q == IDX_MAX) state_d = ST_RUN;
    end else if (mem_update) begin
      table_d[mem_index] = upd_new;
    end
  end

  // Committed history and saturating performance counters.
  always_comb begin
    ghr_d     = ghr_q;
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (upd_accept) begin
      ghr_d = {ghr_q[GHR_WIDTH-2:0], mem_actual_taken};
      if (perf_br_q != PERF_MAX) perf_br_d = perf_br_q + 32'd1;
      if (mispredict && (perf_mp_q != PERF_MAX)) perf_mp_d = perf_mp_q + 32'd1;
    end
  end

  // Prediction register; a same-index update this cycle is bypassed in.
  always_comb begin
    pred_valid_d   = run & fetch_valid;
    pred_counter_d = pred_counter_q;
    pred_index_d   = pred_index_q;
    if (run && fetch_valid) begin
      pred_index_d = fetch_idx;
      if (upd_accept && (mem_index == fetch_idx)) pred_counter_d = upd_new;
      else pred_counter_d = table_q[fetch_idx];
    end
  end

  // State registers; the table itself is cleared by the sweep, not by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_INIT;
      init_ptr_q     <= '0;
      ghr_q          <= '0;
      perf_br_q      <= '0;
      perf_mp_q      <= '0;
      pred_valid_q   <= 1'b0;
      pred_counter_q <= WEAK_NT;
      pred_index_q   <= '0;
    end else begin
      state_q        <= state_d;
      init_ptr_q     <= init_ptr_d;
      table_q        <= table_d;
      ghr_q          <= ghr_d;
      perf_br_q      <= perf_br_d;
      perf_mp_q      <= perf_mp_d;
      pred_valid_q   <= pred_valid_d;
      pred_counter_q <= pred_counter_d;
      pred_index_q   <= pred_index_d;
    end
  end

  assign ready            = run;
  assign pred_valid       = pred_valid_q;
  assign pred_counter     = pred_counter_q;
  assign pred_taken       = pred_counter_q[CTR_WIDTH-1];
  assign pred_index       = pred_index_q;
  assign ghr              = ghr_q;
  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;

endmodule

// File: doc/branch_pattern_table.md
Name: branch_pattern_table

Overview:
Parametrised pattern history table (PHT) of N-bit saturating counters. Fetch stage reads it; MEM stage writes it back when a branch resolves. Optional gshare indexing XORs PC bits with a committed global history register (GHR). Contains a reset-time init sweep FSM and mispredict performance counters.

Parameters:
CTR_WIDTH, 2, width of each saturating counter (>=2)
INDEX_WIDTH, 6, log2 of table entries (64 entries)
GHR_WIDTH, 6, global history length (<= INDEX_WIDTH)
USE_GSHARE, 1, 1 = index is PC bits XOR GHR; 0 = index is PC bits only
PC_LSB, 2, lowest PC bit used for indexing

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_valid  in  1  lookup request this cycle
fetch_pc  in  32  PC being fetched
pred_valid  out  1  prediction valid (registered)
pred_taken  out  1  MSB of pred_counter
pred_counter  out  CTR_WIDTH  counter read; carried down the pipeline
pred_index  out  INDEX_WIDTH  index used; carried down the pipeline
ready  out  1  table initialised; lookups and updates accepted
mem_update  in  1  resolved conditional branch in MEM
mem_index  in  INDEX_WIDTH  index carried from fetch
mem_counter  in  CTR_WIDTH  counter value carried from fetch
mem_actual_taken  in  1  resolved outcome
ghr  out  GHR_WIDTH  committed global history
perf_branches  out  32  count of accepted updates
perf_mispredicts  out  32  count of accepted mispredicted updates

Behaviour:
- Reset: rst high in any state (including mid-sweep) -> state INIT, init_ptr=0, ghr=0, perf counters=0, pred_valid=0, pred_taken=0, pred_counter=WEAK_NT, pred_index=0, ready=0. WEAK_NT = 2^(CTR_WIDTH-1)-1 (01 for 2-bit).
- INIT: each cycle writes WEAK_NT to entry init_ptr, then init_ptr++. After the entry 2^INDEX_WIDTH-1 write -> RUN. ready=0 throughout INIT.
- INIT: fetch_valid is ignored (pred_valid stays 0). mem_update is ignored: no table write, no GHR shift, no perf count.
- RUN: ready=1. RUN is left only by rst.
- Index: idx = fetch_pc[PC_LSB+INDEX_WIDTH-1:PC_LSB]. If USE_GSHARE, the low GHR_WIDTH bits of idx are XORed with ghr.
- Lookup latency is 1 cycle. On a fetch_valid cycle in RUN, the next cycle shows pred_valid=1 with pred_counter=table[idx] and pred_index=idx. Otherwise pred_valid=0 and the other pred outputs hold.
- Update (RUN and mem_update): new = mem_actual_taken ? sat_inc(mem_counter) : sat_dec(mem_counter). Counters saturate at all-ones and at 0; no wrap.
- Update writes table[mem_index]=new at the clock edge.
- Update shifts the GHR: ghr <= {ghr[GHR_WIDTH-2:0], mem_actual_taken}.
- Mispredict = mem_counter[MSB] != mem_actual_taken.
- perf_branches increments on each accepted update; perf_mispredicts increments on each accepted mispredicted update. Both saturate at 2^32-1.
- Same-cycle read/write to the same index is write-first: the prediction returns the new value.
- Same-cycle GHR: the lookup index uses the pre-update ghr.
- Stale update: the table write uses mem_counter, not the current table entry, so the last writer wins.
- Sizing: the table is a flat register array; the implementation is 120-400 lines of RTL.

Test Plan:
- Init sweep: assert rst 1 cycle, then drive fetch_valid every cycle -> ready=0 and pred_valid=0 for 64 cycles; ready=1 on cycle 65; a lookup of any PC then returns pred_counter=01, pred_taken=0.
- Saturation (USE_GSHARE=0): four taken updates to idx 5, each feeding back the counter just read -> counter reads 10, 11, 11, 11; four not-taken updates -> 10, 01, 00, 00; pred_taken follows the MSB.
- Gshare indexing: two taken updates -> ghr=6'b000011; lookup fetch_pc=0x40 -> pred_index=0x10^0x03=0x13.
- Bypass: same cycle, fetch_pc=0x14 (idx 5) and an update to idx 5 with mem_counter=01, taken=1 -> next cycle pred_counter=10.
- Mid-sweep reset: rst at init cycle 30 -> sweep restarts at 0; ready rises exactly 64 cycles after rst deasserts.
- INIT updates ignored, then perf counting: an update during INIT -> perf_branches=0 and ghr unchanged. In RUN, 3 updates (mem_counter=10 with taken=0,1,0) -> perf_branches=3, perf_mispredicts=2.
